// File: rtl/flash_cmd_arbiter.sv
// rtl/flash_cmd_arbiter.sv - two-port arbiter sharing the flash_spi command port
// Grants one op at a time, inserts WREN before erase/program, waits for Done_Sig, then settles.
module flash_cmd_arbiter #(
  parameter logic [3:0]  CT_SIMPLE  = 4'b1001,
  parameter logic [3:0]  CT_PROG    = 4'b1101,
  parameter logic [3:0]  CT_READ    = 4'b1000,
  parameter int unsigned ERASE_WAIT = 100,
  parameter int unsigned PROG_WAIT  = 100,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic        clk24M,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [1:0]  a_op,
  input  logic [23:0] a_addr,
  output logic        a_ack,
  output logic        a_done,
  output logic        a_err,
  output logic [7:0]  a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic [1:0]  b_op,
  input  logic [23:0] b_addr,
  output logic        b_ack,
  output logic        b_done,
  output logic        b_err,
  output logic [7:0]  b_rdata,
  output logic        b_rvalid,
  output logic [3:0]  cmd_type,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  input  logic        Done_Sig,
  input  logic [7:0]  mydata_o,
  input  logic        myvalid_o,
  output logic        busy
);

  localparam logic [1:0]  OP_READ    = 2'b00;
  localparam logic [1:0]  OP_ERASE   = 2'b01;
  localparam logic [1:0]  OP_PROG    = 2'b10;
  localparam logic [1:0]  OP_RSVD    = 2'b11;
  localparam logic [31:0] ERASE_LAST = 32'(ERASE_WAIT - 1);
  localparam logic [31:0] PROG_LAST  = 32'(PROG_WAIT - 1);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN,
    ST_GAP,
    ST_CMD,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [23:0] addr_q;
  logic        owner_q;       // 0 = port A, 1 = port B
  logic        last_grant_q;
  logic [31:0] cnt_q;
  logic        fin_err_q;

  logic        win_b;
  logic [1:0]  win_op;
  logic [23:0] win_addr;
  logic        grant;
  logic        rsvd;
  logic        tmo;
  logic        cnt_clr;
  logic        wait_last;

  always_ff @(posedge clk24M or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    rsvd      = 1'b0;
    tmo       = 1'b0;
    cnt_clr   = 1'b0;
    // On a tie the port that did not win last time goes first.
    win_b     = !(a_req && (!b_req || last_grant_q));
    win_op    = win_b ? b_op : a_op;
    win_addr  = win_b ? b_addr : a_addr;
    wait_last = (op_q == OP_ERASE) ? (cnt_q == ERASE_LAST) : (cnt_q == PROG_LAST);
    case (state)
      ST_IDLE: begin
        // Skip the cycle an ack is visible so a still-high req is not granted twice.
        if ((a_req || b_req) && !a_ack && !b_ack) begin
          grant   = 1'b1;
          cnt_clr = 1'b1;
          case (win_op)
            OP_RSVD: rsvd      = 1'b1;
            OP_READ: state_nxt = ST_CMD;
            default: state_nxt = ST_WREN;
          endcase
        end
      end
      ST_WREN: begin
        if (Done_Sig) begin
          state_nxt = ST_GAP;
        end else if (cnt_q == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_CMD;
      end
      ST_CMD: begin
        if (Done_Sig) begin
          cnt_clr   = 1'b1;
          state_nxt = (op_q == OP_READ) ? ST_DONE : ST_WAIT;
        end else if (cnt_q == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk24M or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_READ;
      addr_q       <= 24'h0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 32'h0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      fin_err_q    <= 1'b0;
    end else begin
      a_ack     <= grant && !win_b;
      b_ack     <= grant && win_b;
      fin_err_q <= rsvd || tmo;
      cnt_q     <= cnt_clr ? 32'h0 : cnt_q + 32'h1;
      if (grant) begin
        op_q         <= win_op;
        addr_q       <= win_addr;
        owner_q      <= win_b;
        last_grant_q <= win_b;
      end
    end
  end

  always_comb begin
    cmd_type   = 4'h0;
    flash_cmd  = 8'h00;
    flash_addr = 24'h0;
    case (state)
      ST_WREN: begin
        cmd_type  = CT_SIMPLE;
        flash_cmd = 8'h06;
      end
      ST_CMD: begin
        case (op_q)
          OP_ERASE: begin
            cmd_type   = CT_SIMPLE;
            flash_cmd  = 8'h20;
            flash_addr = addr_q & 24'hFFF000;
          end
          OP_PROG: begin
            cmd_type   = CT_PROG;
            flash_cmd  = 8'h02;
            flash_addr = addr_q & 24'hFFFF00;
          end
          default: begin
            cmd_type   = CT_READ;
            flash_cmd  = 8'h03;
            flash_addr = addr_q;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign a_done   = !owner_q && (fin_err_q || state == ST_DONE);
  assign b_done   = owner_q && (fin_err_q || state == ST_DONE);
  assign a_err    = !owner_q && fin_err_q;
  assign b_err    = owner_q && fin_err_q;
  assign a_rvalid = (state == ST_CMD) && !owner_q && myvalid_o;
  assign b_rvalid = (state == ST_CMD) && owner_q && myvalid_o;
  assign a_rdata  = ((state == ST_CMD) && !owner_q) ? mydata_o : 8'h00;
  assign b_rdata  = ((state == ST_CMD) && owner_q) ? mydata_o : 8'h00;

endmodule
